unidade_de_busca: RTL

UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

---
 rtl/unidade_de_busca.sv | 128 ++++++++++++
 1 files changed

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: issues one outstanding memory read at a time, computes
// the next PC for contador_de_programa and buffers fetched bytes in a 2-entry queue.
module unidade_de_busca #(
  parameter int PC_STEP = 4,
  parameter int QDEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] curr_pc,
  output logic [7:0] next_pc,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic       mem_rvalid,
  input  logic [7:0] mem_rdata,
  output logic       inst_valid,
  output logic [7:0] inst_pc,
  output logic [7:0] inst_data,
  input  logic       inst_ready
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_count;
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [7:0] r_req_pc;
  logic [7:0] r_q_pc   [QDEPTH];
  logic [7:0] r_q_data [QDEPTH];

  logic w_full;
  logic w_mem_req;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // Issue is also gated by rst_n so nothing leaves the unit while reset is held.
  assign w_full    = (r_count == 2'(QDEPTH));
  assign w_mem_req = rst_n && (r_state == ST_REQ) && !w_full && !redirect;
  assign w_accept  = w_mem_req && mem_ack;
  assign w_push    = (r_state == ST_WAIT) && mem_rvalid && !redirect;
  assign w_pop     = (r_count != 2'd0) && inst_ready;

  assign mem_req    = w_mem_req;
  assign mem_addr   = curr_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign inst_data  = r_q_data[r_rd_ptr];

  always_comb begin
    next_pc = curr_pc;
    if (!rst_n) begin
      next_pc = curr_pc;
    end else if (redirect) begin
      next_pc = redirect_pc;
    end else if (w_accept) begin
      next_pc = curr_pc + 8'(PC_STEP);
    end else begin
      next_pc = curr_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_REQ;
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_req_pc <= 8'h00;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_pc[i]   <= 8'h00;
        r_q_data[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_state  <= ST_WAIT;
            r_req_pc <= curr_pc;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            r_state <= mem_rvalid ? ST_REQ : ST_DROP;
          end else if (mem_rvalid) begin
            r_state <= ST_REQ;
          end
        end
        // A response arriving here belongs to a squashed fetch; it is always
        // consumed so the unit cannot wait forever for a second one.
        ST_DROP: begin
          if (mem_rvalid) begin
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase

      if (redirect) begin
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_q_pc[r_wr_ptr]   <= r_req_pc;
          r_q_data[r_wr_ptr] <= mem_rdata;
          r_wr_ptr           <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
